// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: in-order valid/ready request front-end for a single-port SRAM.
// Commands are buffered, issued one per cycle from the head only, and read
// data returns in request order through a buffered response port. Reads are
// credit-gated so the response FIFO can never overflow.
// Optional feature: define SRAM_REQ_RANGE_CHK_EN to flag addresses >= DEPTH.
module sram_req_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dataout,
  output logic              busy
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
`ifdef SRAM_REQ_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0]  cmd_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     cmd_wr_ptr_reg, cmd_rd_ptr_reg;
  logic [CW-1:0]     cmd_count_reg, cmd_count_next;
  logic              cmd_full_reg, cmd_empty_reg;
  logic              cmd_push, cmd_pop;
  logic [CMD_W-1:0]  head;
  logic              head_rw;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  // ---------------- issue / read pipe ----------------
  logic [CW:0]       credit_used;
  logic              read_ok, issue, head_oor, pin_update, read_issue;
  logic [RD_LAT:0]   rd_pipe_reg, rd_pipe_next;
  logic [RD_LAT:0]   err_pipe_reg, err_pipe_next;
  logic              rd_exit, exit_err;
  logic [CW-1:0]     rif_reg;

  // ---------------- response FIFO ----------------
  logic [DATA_W:0]   resp_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     resp_wr_ptr_reg, resp_rd_ptr_reg;
  logic [CW-1:0]     resp_count_reg, resp_count_next;
  logic              resp_full_reg, resp_empty_reg;
  logic              resp_push, resp_pop;
  logic [DATA_W:0]   resp_head;

  assign req_ready  = !cmd_full_reg;
  assign cmd_push   = req_valid && !cmd_full_reg;
  assign head       = cmd_mem[cmd_rd_ptr_reg];
  assign head_rw    = head[CMD_W-1];
  assign head_addr  = head[ADDR_W+DATA_W-1:DATA_W];
  assign head_wdata = head[DATA_W-1:0];

  // A read may issue only if its response has a guaranteed slot.
  assign credit_used = {1'b0, rif_reg} + {1'b0, resp_count_reg};
  assign read_ok     = credit_used < (CW+1)'(FIFO_DEPTH);
  assign issue       = !cmd_empty_reg && (head_rw || read_ok);
  assign cmd_pop     = issue;
  assign head_oor    = RANGE_CHK && ({1'b0, head_addr} >= (ADDR_W+1)'(DEPTH));
  assign pin_update  = issue && !head_oor;
  assign read_issue  = issue && !head_rw;

  // Stage 0 lines up with the pin register; the tag exits at stage RD_LAT,
  // the cycle in which sram_dataout holds the data for that read.
  assign rd_pipe_next[0]  = read_issue;
  assign err_pipe_next[0] = read_issue && head_oor;
  genvar gi;
  generate
    for (gi = 1; gi <= RD_LAT; gi++) begin : g_rd_pipe
      assign rd_pipe_next[gi]  = rd_pipe_reg[gi-1];
      assign err_pipe_next[gi] = err_pipe_reg[gi-1];
    end
  endgenerate
  assign rd_exit  = rd_pipe_reg[RD_LAT];
  assign exit_err = err_pipe_reg[RD_LAT];

  assign resp_push  = rd_exit;
  assign resp_valid = !resp_empty_reg;
  assign resp_pop   = resp_valid && resp_ready;
  assign resp_head  = resp_mem[resp_rd_ptr_reg];
  assign resp_rdata = resp_valid ? resp_head[DATA_W-1:0] : '0;
  assign resp_err   = resp_valid && resp_head[DATA_W];

  assign busy = !cmd_empty_reg || (rif_reg != '0) || !resp_empty_reg;

  // Next occupancy of both FIFOs; flags are registered from these.
  always_comb begin
    cmd_count_next  = cmd_count_reg + CW'(cmd_push) - CW'(cmd_pop);
    resp_count_next = resp_count_reg + CW'(resp_push) - CW'(resp_pop);
  end

  // Command FIFO storage (not reset; validity comes from the pointers).
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr_reg] <= {req_rw, req_addr, req_wdata};
  end

  // Response FIFO storage; out-of-range reads return zero data.
  always_ff @(posedge clk) begin
    if (resp_push) resp_mem[resp_wr_ptr_reg] <= {exit_err, exit_err ? '0 : sram_dataout};
  end

  // FIFO pointers, counts and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr_reg  <= '0;
      cmd_rd_ptr_reg  <= '0;
      cmd_count_reg   <= '0;
      cmd_full_reg    <= 1'b0;
      cmd_empty_reg   <= 1'b1;
      resp_wr_ptr_reg <= '0;
      resp_rd_ptr_reg <= '0;
      resp_count_reg  <= '0;
      resp_full_reg   <= 1'b0;
      resp_empty_reg  <= 1'b1;
    end else begin
      if (cmd_push)  cmd_wr_ptr_reg  <= cmd_wr_ptr_reg + PW'(1);
      if (cmd_pop)   cmd_rd_ptr_reg  <= cmd_rd_ptr_reg + PW'(1);
      if (resp_push) resp_wr_ptr_reg <= resp_wr_ptr_reg + PW'(1);
      if (resp_pop)  resp_rd_ptr_reg <= resp_rd_ptr_reg + PW'(1);
      cmd_count_reg  <= cmd_count_next;
      cmd_full_reg   <= (cmd_count_next == CW'(FIFO_DEPTH));
      cmd_empty_reg  <= (cmd_count_next == '0);
      resp_count_reg <= resp_count_next;
      resp_full_reg  <= (resp_count_next == CW'(FIFO_DEPTH));
      resp_empty_reg <= (resp_count_next == '0);
    end
  end

  // Registered SRAM pins: rw pulses only on a real write, addr/din hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rw   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      sram_rw <= pin_update && head_rw;
      if (pin_update) begin
        sram_addr <= head_addr;
        sram_din  <= head_wdata;
      end
    end
  end

  // Read-latency tag pipe and in-flight read count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_reg  <= '0;
      err_pipe_reg <= '0;
      rif_reg      <= '0;
    end else begin
      rd_pipe_reg  <= rd_pipe_next;
      err_pipe_reg <= err_pipe_next;
      rif_reg      <= rif_reg + CW'(read_issue) - CW'(rd_exit);
    end
  end

  // The read credit must keep the response FIFO from ever overflowing.
  assert property (@(posedge clk) disable iff (rst) !(resp_push && resp_full_reg))
    else $error("sram_req_ctrl: response FIFO overflow");

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port sram block and drives its rw/addr/din pins.
- Accepts buffered valid/ready read/write requests, issues at most one op per cycle in strict order, and tracks SRAM read latency.
- Returns read data in request order through a valid/ready response port with its own buffering.

Parameters:
- ADDR_W, 4, address width in bits.
- DATA_W, 8, data width in bits.
- DEPTH, 16, number of implemented SRAM words; must be at most 2**ADDR_W.
- FIFO_DEPTH, 4, entries in each of the command FIFO and the response FIFO; power of 2, at least 2.
- RD_LAT, 1, cycles from a read issue edge until sram_dataout is valid; 1 to 3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  command FIFO not full.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response FIFO not empty.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data.
- resp_err  out  1  address out of range (feature only; otherwise 0).
- sram_rw  out  1  to sram rw.
- sram_addr  out  ADDR_W  to sram addr.
- sram_din  out  DATA_W  to sram din.
- sram_dataout  in  DATA_W  from sram dataout.
- busy  out  1  command FIFO non-empty OR read in flight OR response FIFO non-empty.

Behaviour:
- Reset (asynchronous) clears both FIFOs, the latency pipe and the in-flight count.
- Output values in reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, sram_rw=0, sram_addr=0, sram_din=0, busy=0.
- Requests in flight when reset asserts are discarded; no response is produced for them.
- Request accept: push on req_valid && req_ready.
  - req_ready = !cmd_full, registered-flag based.
  - A push and a pop in the same cycle on a full FIFO is not allowed; req_ready must already be 0.
- Issue rule: the head command issues in a cycle where cmd_empty is 0 and one of these holds:
  - the command is a write, or
  - the command is a read and (reads_in_flight + resp_count) < FIFO_DEPTH.
- Only the head is eligible; there is no reordering. A blocked read stalls every command behind it.
- SRAM pins are registered.
  - On an issue, at the next edge sram_rw/addr/din take the command values.
  - With no issue, sram_rw=0, sram_addr holds, sram_din holds. An idle read is side-effect-free.
- Read return:
  - A read issue pushes a 1 into a RD_LAT-deep valid shift pipe.
  - When the bit exits the pipe, sram_dataout is captured into the response FIFO.
  - Issue-to-resp_valid latency with empty FIFOs is 1 (pin register) + RD_LAT + 1 (FIFO write), i.e. 3 cycles at RD_LAT=1.
- Response FIFO pops on resp_valid && resp_ready. The credit check above guarantees it never overflows, and that must hold as an assertion.
- Ordering: strict program order. A write followed by a read to the same address returns the new data, because the write reaches the SRAM one cycle earlier.
- Back-to-back: full throughput of one op per cycle while resp_ready=1.
- reads_in_flight increments on read issue, decrements when the pipe bit exits, and both may happen in one cycle.
- Pointers wrap modulo FIFO_DEPTH; occupancy counters are $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: SRAM_REQ_RANGE_CHK_EN.
- When defined, a request with addr >= DEPTH is out of range:
  - Write: consumed from the command FIFO with no SRAM access; sram_rw stays 0.
  - Read: follows the normal issue and pipe path, including credit and ordering. The SRAM pins are not updated. The response is resp_rdata=0, resp_err=1.
  - In-range responses have resp_err=0.
- When not defined, there is no check: addresses go straight to the SRAM and resp_err is tied 0.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst while 2 reads are in flight.
  - Response: no resp_valid afterwards; req_ready=1, busy=0 next cycle.
- Write then read:
  - Stimulus: write addr 3 data 0xA5 then read addr 3, back-to-back, resp_ready=1.
  - Response: resp_valid 4 cycles after the read is accepted, resp_rdata=0xA5, resp_err=0.
- Streaming:
  - Stimulus: writes 0x10..0x1F to addr 0..15, then 16 reads.
  - Response: responses 0x10..0x1F in order, one per cycle once streaming.
- Response backpressure:
  - Stimulus: resp_ready=0, 8 reads.
  - Response: exactly 4 responses buffered, reads_in_flight=0, head read stalled, req_ready drops after 4 more accepts. With resp_ready=1 the rest drain in order.
- Command FIFO full:
  - Stimulus: hold the issue stalled by backpressure, push 4 writes.
  - Response: req_ready=0; a 5th req_valid is not accepted until the FIFO drains.
- Range check (with SRAM_REQ_RANGE_CHK_EN, DEPTH=12):
  - Stimulus: write addr 13, then read addr 13, then read addr 2.
  - Response: no SRAM write occurs. Responses in order: (0, err=1) then (data of addr 2, err=0).
